// File: rtl/image_pipe_pkg.sv
// -----------------------------------------------------------------------------
// image_pipe_pkg
// Shared types and constants for the image pipeline frame controller:
//   - state_t : controller FSM states
//   - cfg_t   : run-time configuration bundle (sobel threshold, gray method,
//               median bypass)
//   - reset defaults for the shadowed configuration
// -----------------------------------------------------------------------------
package image_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic METHOD_AVERAGE = 1'b0;
    localparam logic METHOD_WEIGHT  = 1'b1;

    localparam logic [7:0] DEF_THRESHOLD = 8'd128;
    localparam logic       DEF_METHOD    = METHOD_WEIGHT;
    localparam logic       DEF_BYPASS    = 1'b0;

    typedef struct packed {
        logic [7:0] threshold;
        logic       method;
        logic       bypass;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        threshold: DEF_THRESHOLD,
        method:    DEF_METHOD,
        bypass:    DEF_BYPASS
    };

endpackage

// File: rtl/frame_geom_checker.sv
// -----------------------------------------------------------------------------
// frame_geom_checker
// Edge detection on source timing and the pipeline tail, plus frame geometry
// checking (pixels per line, lines per frame).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/hsync/vsync    source timing (active-high levels)
//   tail_vsync              vsync from the end of the pipeline
//   gate                    stream gate is open this cycle (pixels counted)
//   run                     controller is in RUN (line ends and check active)
//   clr                     restart counters (frame admitted this cycle)
//   err_clr                 clear sticky err_geom
//   vsync_rise, vsync_fall  combinational edge strobes of in_vsync
//   tail_fall               combinational falling-edge strobe of tail_vsync
//   err_geom                sticky geometry error
// -----------------------------------------------------------------------------
module frame_geom_checker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_hsync,
    input  logic in_vsync,
    input  logic tail_vsync,
    input  logic gate,
    input  logic run,
    input  logic clr,
    input  logic err_clr,
    output logic vsync_rise,
    output logic vsync_fall,
    output logic tail_fall,
    output logic err_geom
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_ACTIVE);

    logic             vsync_q;
    logic             hsync_q;
    logic             tail_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic             line_bad;

    logic             hsync_fall;
    logic             pix_inc;
    logic             line_end;
    logic [CNT_W-1:0] line_cnt_eff;
    logic             line_bad_eff;
    logic             geom_bad;

    assign vsync_rise = in_vsync & ~vsync_q;
    assign vsync_fall = ~in_vsync & vsync_q;
    assign hsync_fall = ~in_hsync & hsync_q;
    assign tail_fall  = ~tail_vsync & tail_q;

    assign pix_inc  = gate & in_valid & in_hsync;
    assign line_end = run & hsync_fall;

    // A line ending in the same cycle as the frame must be folded into the
    // geometry check, so the check looks at the post-update line state.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        line_cnt_eff = line_cnt;
        line_bad_eff = line_bad;
        if (line_end) begin
            if (line_cnt != CNT_MAX) begin
                line_cnt_eff = line_cnt + 1'b1;
            end
            if (pix_cnt != H_EXP) begin
                line_bad_eff = 1'b1;
            end
        end
        geom_bad = run & vsync_fall & ((line_cnt_eff != V_EXP) | line_bad_eff);
    end

    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            tail_q   <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_bad <= 1'b0;
            err_geom <= 1'b0;
        end else begin
            vsync_q <= in_vsync;
            hsync_q <= in_hsync;
            tail_q  <= tail_vsync;

            if (clr) begin
                pix_cnt  <= {{(CNT_W-1){1'b0}}, pix_inc};
                line_cnt <= '0;
                line_bad <= 1'b0;
            end else begin
                if (line_end) begin
                    pix_cnt <= '0;
                end else if (pix_inc && (pix_cnt != CNT_MAX)) begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
                line_cnt <= line_cnt_eff;
                line_bad <= line_bad_eff;
            end

            // A new error wins over a simultaneous clear.
            if (geom_bad) begin
                err_geom <= 1'b1;
            end else if (err_clr) begin
                err_geom <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/image_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// image_pipe_ctrl
// Frame-level controller in front of the rgb2gray -> median -> sobel chain.
// Opens and closes the pixel stream only on frame boundaries, shadows the
// run-time configuration so it only changes between frames, checks frame
// geometry and tracks drain of the pipeline tail after a stop.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   start, stop                         stream on at next frame / off after current
//   cfg_threshold, cfg_method, cfg_bypass   requested configuration
//   in_valid, in_hsync, in_vsync        source timing
//   tail_vsync                          sobel vsync from the pipeline end
//   pipe_valid, pipe_hsync, pipe_vsync  gated, registered timing into rgb2gray
//   act_threshold, act_method, act_bypass   shadowed configuration
//   busy                                controller not idle
//   frame_done                          1-cycle pulse per tail_vsync fall while busy
//   frame_cnt                           admitted frames (wrapping)
//   err_geom, err_timeout, err_clr      sticky errors and their clear
// -----------------------------------------------------------------------------
module image_pipe_ctrl
    import image_pipe_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int CNT_W         = 12,
    parameter int FRM_W         = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       cfg_threshold,
    input  logic             cfg_method,
    input  logic             cfg_bypass,
    input  logic             in_valid,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             tail_vsync,
    output logic             pipe_valid,
    output logic             pipe_hsync,
    output logic             pipe_vsync,
    output logic [7:0]       act_threshold,
    output logic             act_method,
    output logic             act_bypass,
    output logic             busy,
    output logic             frame_done,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             err_geom,
    output logic             err_timeout,
    input  logic             err_clr
);

    localparam int                DRN_W      = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    cfg_t             act_cfg;
    cfg_t             cfg_req;
    logic             stop_pend;
    logic [DRN_W-1:0] drain_cnt;

    logic gate;
    logic admit;
    logic frame_end;
    logic drain_exit;
    logic timeout_hit;
    logic vsync_rise;
    logic vsync_fall;
    logic tail_fall;

    assign cfg_req = '{threshold: cfg_threshold, method: cfg_method, bypass: cfg_bypass};

    frame_geom_checker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_geom (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .tail_vsync (tail_vsync),
        .gate       (gate),
        .run        (state == RUN),
        .clr        (admit),
        .err_clr    (err_clr),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .tail_fall  (tail_fall),
        .err_geom   (err_geom)
    );

    // Gate opens in the rise cycle itself and closes in the fall cycle, so
    // the registered pipe_vsync is an exact one-cycle-delayed whole frame.
    always_comb begin
        state_nxt   = state;
        gate        = 1'b0;
        admit       = 1'b0;
        frame_end   = 1'b0;
        drain_exit  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (vsync_rise) begin
                    admit     = 1'b1;
                    gate      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                gate = ~vsync_fall;
                if (vsync_fall) begin
                    frame_end = 1'b1;
                    state_nxt = (stop_pend || stop) ? DRAIN : ARM;
                end
            end
            DRAIN: begin
                if (tail_fall) begin
                    drain_exit = 1'b1;
                    state_nxt  = IDLE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    drain_exit  = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stop_pend   <= 1'b0;
            drain_cnt   <= '0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
            frame_done  <= 1'b0;
            act_cfg     <= CFG_DEFAULT;
            pipe_valid  <= 1'b0;
            pipe_hsync  <= 1'b0;
            pipe_vsync  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (drain_exit) begin
                stop_pend <= 1'b0;
            end else if ((state == RUN) && stop) begin
                stop_pend <= 1'b1;
            end

            // Counts cycles spent in DRAIN; held at zero everywhere else.
            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else if (drain_cnt != DRAIN_LAST) begin
                drain_cnt <= drain_cnt + 1'b1;
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            frame_done <= tail_fall & (state != IDLE);

            if (admit) begin
                act_cfg <= cfg_req;
            end

            pipe_valid <= in_valid & gate;
            pipe_hsync <= in_hsync & gate;
            pipe_vsync <= in_vsync & gate;
        end
    end

    assign busy          = (state != IDLE);
    assign act_threshold = act_cfg.threshold;
    assign act_method    = act_cfg.method;
    assign act_bypass    = act_cfg.bypass;

endmodule

// File: tb/tb_image_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_image_pipe_ctrl
// Directed sequence of frames with randomized valid gaps, blanking and
// configuration bits. A frame-level model (streaming flag, admitted-frame
// count, latched configuration, sticky geometry error) supplies every
// expected value. The pipeline tail is modelled as a fixed delay of
// pipe_vsync, with an override to hold it high.
// -----------------------------------------------------------------------------
module tb_image_pipe_ctrl;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int DT  = 64;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [7:0]  cfg_threshold;
    logic        cfg_method, cfg_bypass;
    logic        in_valid, in_hsync, in_vsync;
    logic        tail_vsync;
    logic        pipe_valid, pipe_hsync, pipe_vsync;
    logic [7:0]  act_threshold;
    logic        act_method, act_bypass;
    logic        busy, frame_done;
    logic [15:0] frame_cnt;
    logic        err_geom, err_timeout, err_clr;

    logic [LAT-1:0] tail_sr;
    logic           tail_hold;
    assign tail_vsync = tail_sr[LAT-1] | tail_hold;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fall_cyc = 0;
    int fd_at_fall = 0;
    int fd_a;

    bit         streaming;
    bit         cur_fwd;
    int         exp_frames;
    bit         exp_err;
    logic [7:0] exp_thr;
    logic       exp_meth, exp_byp;

    always #5 clk = ~clk;

    image_pipe_ctrl #(
        .H_ACTIVE      (H),
        .V_ACTIVE      (V),
        .CNT_W         (12),
        .FRM_W         (16),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .cfg_threshold (cfg_threshold),
        .cfg_method    (cfg_method),
        .cfg_bypass    (cfg_bypass),
        .in_valid      (in_valid),
        .in_hsync      (in_hsync),
        .in_vsync      (in_vsync),
        .tail_vsync    (tail_vsync),
        .pipe_valid    (pipe_valid),
        .pipe_hsync    (pipe_hsync),
        .pipe_vsync    (pipe_vsync),
        .act_threshold (act_threshold),
        .act_method    (act_method),
        .act_bypass    (act_bypass),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_geom      (err_geom),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_act(input string tag);
        check({tag, "_thr"},  act_threshold, exp_thr);
        check({tag, "_meth"}, act_method,    exp_meth);
        check({tag, "_byp"},  act_bypass,    exp_byp);
    endtask

    // One clock cycle: drive the inputs, sample 1 ns after the edge and check
    // that the gated outputs are the previous inputs of an admitted frame.
    task automatic step(input logic v, input logic h, input logic val);
        logic ev, eh, eval;
        in_vsync = v;
        in_hsync = h;
        in_valid = val;
        ev   = v   & cur_fwd;
        eh   = h   & cur_fwd;
        eval = val & cur_fwd;
        @(posedge clk);
        #1;
        cyc++;
        tail_sr = {tail_sr[LAT-2:0], pipe_vsync};
        if (frame_done === 1'b1) fd_cnt++;
        check("pipe_vsync", pipe_vsync, ev);
        check("pipe_hsync", pipe_hsync, eh);
        check("pipe_valid", pipe_valid, eval);
    endtask

    task automatic apply_reset_midframe();
        rst_n = 1'b0;
        #2;
        check("rst_pipe_vsync", pipe_vsync, 1'b0);
        check("rst_pipe_valid", pipe_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_geom", err_geom, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        check("rst_act_thr", act_threshold, 8'd128);
        check("rst_act_meth", act_method, 1'b1);
        check("rst_act_byp", act_bypass, 1'b0);
        cur_fwd    = 1'b0;
        streaming  = 1'b0;
        exp_frames = 0;
        exp_err    = 1'b0;
        exp_thr    = 8'd128;
        exp_meth   = 1'b1;
        exp_byp    = 1'b0;
    endtask

    // One source frame. Line-indexed events (1-based) fire in the first
    // blanking cycle of that line; stop_line == 0 means stop on the rise.
    task automatic run_frame(input int n_lines, input int short_line,
                             input int start_line, input int stop_line,
                             input int cfg_line, input logic [7:0] cfg_val,
                             input bit coinc, input bit clr_at_fall,
                             input int rst_line);
        int  npix, p;
        bit  bad;
        logic val;
        cfg_method = 1'($urandom_range(0, 1));
        cfg_bypass = 1'($urandom_range(0, 1));
        if (stop_line == 0) stop = 1'b1;
        cur_fwd = streaming && (stop_line != 0);
        if (stop_line == 0) streaming = 1'b0;
        if (cur_fwd) begin
            exp_thr  = cfg_threshold;
            exp_meth = cfg_method;
            exp_byp  = cfg_bypass;
        end
        step(1'b1, 1'b0, 1'b0);
        stop = 1'b0;
        check_act("act_rise");

        for (int l = 1; l <= n_lines; l++) begin
            if (l == start_line) begin
                start = 1'b1;
                streaming = 1'b1;
            end
            if (l == stop_line) begin
                stop = 1'b1;
                streaming = 1'b0;
            end
            if (l == cfg_line) cfg_threshold = cfg_val;
            if (l == rst_line) apply_reset_midframe();
            step(1'b1, 1'b0, 1'b0);
            start = 1'b0;
            stop  = 1'b0;
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'b0);
            npix = (l == short_line) ? H - 1 : H;
            p = 0;
            while (p < npix) begin
                val = ($urandom_range(0, 3) != 0);
                step(1'b1, 1'b1, val);
                if (val) p++;
            end
            if (!(coinc && l == n_lines)) step(1'b1, 1'b0, 1'b0);
        end
        if (!coinc) step(1'b1, 1'b0, 1'b0);

        check("err_geom_pre", err_geom, exp_err);
        bad = cur_fwd && ((n_lines != V) || (short_line > 0));
        exp_err = bad || (exp_err && !clr_at_fall);
        err_clr = clr_at_fall;
        step(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        fall_cyc   = cyc;
        fd_at_fall = fd_cnt;
        if (cur_fwd) exp_frames++;
        check("err_geom_fall", err_geom, exp_err);
        check("frame_cnt_fall", frame_cnt, exp_frames);
        check_act("act_fall");
        cur_fwd = 1'b0;

        if (rst_n === 1'b0) rst_n = 1'b1;
        repeat (3 + $urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        streaming = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_geom_clr", err_geom, 1'b0);
        check("err_timeout_clr", err_timeout, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; err_clr = 1'b0;
        in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        cfg_threshold = 8'd128; cfg_method = 1'b1; cfg_bypass = 1'b0;
        tail_hold = 1'b0; tail_sr = '0;
        streaming = 1'b0; cur_fwd = 1'b0;
        exp_frames = 0; exp_err = 1'b0;
        exp_thr = 8'd128; exp_meth = 1'b1; exp_byp = 1'b0;

        // Reset state
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_pipe_vsync", pipe_vsync, 1'b0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_err_geom", err_geom, 1'b0);
        check("reset_err_timeout", err_timeout, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check_act("reset_act");
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // start and stop together in IDLE: stays idle
        start = 1'b1; stop = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;
        check("idle_start_stop_busy", busy, 1'b0);

        // start then stop while armed
        pulse_start();
        check("arm_busy", busy, 1'b1);
        stop = 1'b1; streaming = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        check("arm_stop_busy", busy, 1'b0);

        // stop coinciding with the rise: nothing admitted
        pulse_start();
        run_frame(V, 0, -1, 0, -1, 8'd0, 1'b0, 1'b0, -1);
        check("rise_stop_busy", busy, 1'b0);

        // start mid-frame: partial frame never forwarded
        run_frame(V, 0, 2, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        check("midstart_busy", busy, 1'b1);

        // Three frames, threshold changed mid-frame 2
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        run_frame(V, 0, -1, -1, 3, 8'd60, 1'b0, 1'b0, -1);
        check("f2_act_thr_held", act_threshold, 8'd128);
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        check("f3_act_thr", act_threshold, 8'd60);
        check("f3_frame_cnt", frame_cnt, 3);
        check("f3_err_geom", err_geom, 1'b0);

        // stop mid-frame: frame completes, next frame blocked, drain ends on tail fall
        run_frame(V, 0, -1, 3, -1, 8'd0, 1'b0, 1'b0, -1);
        fd_a = fd_at_fall;
        check("stop_drain_busy", busy, 1'b1);
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        check("stop_idle_busy", busy, 1'b0);
        check("stop_frame_done_once", fd_cnt - fd_a, 1);
        check("stop_frame_cnt", frame_cnt, exp_frames);
        check("stop_err_timeout", err_timeout, 1'b0);

        // Geometry errors
        pulse_start();
        run_frame(V, 5, -1, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        check("short_line_err", err_geom, 1'b1);
        clear_errors();
        run_frame(V - 1, 0, -1, -1, -1, 8'd0, 1'b0, 1'b1, -1);
        check("short_frame_err_clr", err_geom, 1'b1);
        clear_errors();
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b1, 1'b0, -1);
        check("coinc_fall_ok", err_geom, 1'b0);
        run_frame(V, V, -1, -1, -1, 8'd0, 1'b1, 1'b0, -1);
        check("coinc_short_last", err_geom, 1'b1);
        clear_errors();

        // Drain timeout with tail held high
        tail_hold = 1'b1;
        run_frame(V, 0, -1, 2, -1, 8'd0, 1'b0, 1'b0, -1);
        while (cyc < fall_cyc + DT - 1) step(1'b0, 1'b0, 1'b0);
        check("drain_busy_before", busy, 1'b1);
        check("drain_to_before", err_timeout, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("drain_busy_after", busy, 1'b0);
        check("drain_to_after", err_timeout, 1'b1);
        clear_errors();
        tail_hold = 1'b0;
        repeat (LAT + 2) step(1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then restart
        pulse_start();
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b0, 1'b0, 4);
        check("post_rst_busy", busy, 1'b0);
        pulse_start();
        run_frame(V, 0, -1, -1, -1, 8'd0, 1'b0, 1'b0, -1);
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_err_geom", err_geom, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
